// File: rtl/axi_mem_pkg.sv
// Shared encodings for the AXI4 memory slave: burst types, response codes
// and the state constants of the independent read and write engines.
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_DATA      = 2'd1;
    localparam logic [1:0] W_RESP      = 2'd2;

    localparam logic [0:0] R_IDLE      = 1'b0;
    localparam logic [0:0] R_DATA      = 1'b1;

endpackage

// File: rtl/axi_mem_array.sv
// 64-bit wide backing RAM: one byte-strobed write port and one registered,
// read-first read port. Contents are reachable hierarchically as ram.mem.
module axi_mem_array
    import axi_mem_pkg::*;
#(
    parameter int DEPTH     = 8192,
    parameter int IDX_W     = 13,
    parameter     INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [63:0]      wdata,
    input  logic [7:0]       wstrb,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [63:0]      rdata
);

    logic [63:0] mem [0:DEPTH-1];

    // NOTE: storage has no reset branch; contents must survive rst_n and a
    // reset on an array would turn the RAM into a huge flop bank.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 8; k++) begin
                if (wstrb[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave RAM: independent single-outstanding read and write engines
// supporting FIXED/INCR/WRAP bursts of up to 256 beats over axi_mem_array.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int          ID_WIDTH  = 6,
    parameter int unsigned MEM_SIZE  = 32'h10000,
    parameter              INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_WIDTH-1:0] i_awid,
    input  logic [31:0]         i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [2:0]          i_awsize,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [ID_WIDTH-1:0] i_arid,
    input  logic [31:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    input  logic [63:0]         i_wdata,
    input  logic [7:0]          i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [ID_WIDTH-1:0] o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready,
    output logic [ID_WIDTH-1:0] o_rid,
    output logic [63:0]         o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready
);

    localparam int DEPTH = int'(MEM_SIZE / 8);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [1:0]  sz;
        logic [31:0] step, nxt, wrap_mask;
        sz        = (size > 3'd3) ? 2'd3 : size[1:0];
        step      = 32'd1 << sz;
        nxt       = (addr & ~(step - 32'd1)) + step;
        wrap_mask = (({24'd0, len} + 32'd1) << sz) - 32'd1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (nxt & wrap_mask);
            default:     next_addr = nxt;
        endcase
    endfunction

    // Upper address bits are dropped, so the RAM aliases every MEM_SIZE bytes.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] w;
        w = (addr >> 3) & 32'(DEPTH - 1);
        return w[IDX_W-1:0];
    endfunction

    logic [1:0]          w_state;
    logic [ID_WIDTH-1:0] w_id;
    logic [31:0]         w_addr, w_next;
    logic [7:0]          w_len, w_cnt;
    logic [2:0]          w_size;
    logic [1:0]          w_burst;

    logic [0:0]          r_state;
    logic [ID_WIDTH-1:0] r_id;
    logic [31:0]         r_addr, r_next;
    logic [7:0]          r_len, r_cnt;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;

    logic                w_hs, ar_hs, r_hs, r_last;
    logic                ram_re;
    logic [IDX_W-1:0]    ram_raddr;
    logic                unused_wlast;

    assign unused_wlast = i_wlast;

    assign w_next = next_addr(w_addr, w_size, w_len, w_burst);
    assign r_next = next_addr(r_addr, r_size, r_len, r_burst);

    assign w_hs   = i_wvalid && (w_state == W_DATA);
    assign ar_hs  = i_arvalid && (r_state == R_IDLE);
    assign r_hs   = i_rready && (r_state == R_DATA);
    assign r_last = (r_state == R_DATA) && (r_cnt == r_len);

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = word_idx(r_next);
        if (ar_hs) begin
            ram_re    = 1'b1;
            ram_raddr = word_idx(i_araddr);
        end else if (r_hs && !r_last) begin
            ram_re    = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (i_awvalid) begin
                    w_id    <= i_awid;
                    w_addr  <= i_awaddr;
                    w_len   <= i_awlen;
                    w_size  <= i_awsize;
                    w_burst <= i_awburst;
                    w_cnt   <= '0;
                    w_state <= W_DATA;
                end
                W_DATA: if (i_wvalid) begin
                    if (w_cnt == w_len) begin
                        w_state <= W_RESP;
                    end else begin
                        w_cnt  <= w_cnt + 8'd1;
                        w_addr <= w_next;
                    end
                end
                W_RESP: if (i_bready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (i_arvalid) begin
                    r_id    <= i_arid;
                    r_addr  <= i_araddr;
                    r_len   <= i_arlen;
                    r_size  <= i_arsize;
                    r_burst <= i_arburst;
                    r_cnt   <= '0;
                    r_state <= R_DATA;
                end
                R_DATA: if (i_rready) begin
                    if (r_last) begin
                        r_state <= R_IDLE;
                    end else begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_addr <= r_next;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    axi_mem_array #(
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) ram (
        .clk   (clk),
        .we    (w_hs),
        .waddr (word_idx(w_addr)),
        .wdata (i_wdata),
        .wstrb (i_wstrb),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (o_rdata)
    );

    assign o_awready = (w_state == W_IDLE);
    assign o_wready  = (w_state == W_DATA);
    assign o_bvalid  = (w_state == W_RESP);
    assign o_bid     = w_id;
    assign o_bresp   = RESP_OKAY;

    assign o_arready = (r_state == R_IDLE);
    assign o_rvalid  = (r_state == R_DATA);
    assign o_rlast   = r_last;
    assign o_rid     = r_id;
    assign o_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: directed burst scenarios plus random
// bursts checked against a word-array model built from the burst address rules.
module tb_axi_mem_slave;

    localparam int unsigned MEM_SIZE = 32'h10000;
    localparam int          TMO      = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  awid = '0, arid = '0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0;
    logic        awvalid = 1'b0, arvalid = 1'b0;
    logic        awready, arready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, wready;
    logic [5:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready = 1'b0;
    logic [63:0] rdata;
    logic        rlast, rvalid, rready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [63:0] model [0:MEM_SIZE/8-1];
    logic [63:0] wbuf  [0:255];
    logic [7:0]  sbuf  [0:255];
    logic [63:0] rbuf  [0:255];
    time         aw_time, ar_time;

    always #5 clk = ~clk;

    axi_mem_slave #(.ID_WIDTH(6), .MEM_SIZE(MEM_SIZE), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n),
        .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize),
        .i_awburst(awburst), .i_awvalid(awvalid), .o_awready(awready),
        .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize),
        .i_arburst(arburst), .i_arvalid(arvalid), .o_arready(arready),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
        .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
        .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast),
        .o_rvalid(rvalid), .i_rready(rready)
    );

    // Byte address of beat i, straight from the burst definitions.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                              input int len, input logic [1:0] burst, input int i);
        int unsigned step, wbytes;
        logic [31:0] al, base;
        step = 1 << ((size > 3) ? 3 : size);
        al   = a - (a % step);
        case (burst)
            2'd0: return a;
            2'd2: begin
                wbytes = (len + 1) * step;
                base   = al - (al % wbytes);
                return base + ((al - base) + i * step) % wbytes;
            end
            default: return (i == 0) ? a : al + i * step;
        endcase
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return (a % MEM_SIZE) / 8;
    endfunction

    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        int unsigned w;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin
            checks++; failures++; awvalid = 1'b0;
            $display("FAIL aw_timeout: awready stayed %0b, required 1", awready);
            return;
        end
        aw_time = $time;
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == len); wvalid = 1'b1;
            n = 0;
            while (!wready && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) begin
                checks++; failures++; wvalid = 1'b0;
                $display("FAIL w_timeout: beat %0d wready=%0b, required 1", i, wready);
                return;
            end
            @(negedge clk);
            w = widx(beat_addr(addr, size, len, burst, i));
            for (int k = 0; k < 8; k++) if (sbuf[i][k]) model[w][8*k +: 8] = wbuf[i][8*k +: 8];
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < TMO) begin @(negedge clk); n++; end
        checks++;
        if (bvalid !== 1'b1) begin
            failures++; bready = 1'b0;
            $display("FAIL b_timeout: bvalid=%0b, required 1", bvalid);
            return;
        end
        checks++;
        if (bid !== id) begin failures++; $display("FAIL bid: got %0d, expected %0d", bid, id); end
        checks++;
        if (bresp !== 2'd0) begin failures++; $display("FAIL bresp: got %0d, expected 0", bresp); end
        @(negedge clk);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            failures++;
            $display("FAIL b_done: bvalid=%0b awready=%0b, expected 0/1", bvalid, awready);
        end
    endtask

    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int hold_beat);
        int n;
        logic [63:0] exp;
        @(negedge clk);
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
        arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin
            checks++; failures++; arvalid = 1'b0;
            $display("FAIL ar_timeout: arready stayed %0b, required 1", arready);
            return;
        end
        ar_time = $time;
        @(negedge clk);
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin failures++; $display("FAIL r_latency: rvalid=%0b, expected 1", rvalid); end
        for (int i = 0; i <= len; i++) begin
            exp = model[widx(beat_addr(addr, size, len, burst, i))];
            if (i == hold_beat) begin
                rready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    checks++;
                    if (rvalid !== 1'b1 || rdata !== exp) begin
                        failures++;
                        $display("FAIL r_stable: cycle %0d rvalid=%0b rdata=%h, expected 1/%h", h, rvalid, rdata, exp);
                    end
                    @(negedge clk);
                end
            end
            rready = 1'b1;
            n = 0;
            while (!rvalid && n < TMO) begin @(negedge clk); n++; end
            checks++;
            if (rvalid !== 1'b1) begin
                failures++; rready = 1'b0;
                $display("FAIL r_timeout: beat %0d rvalid=%0b, required 1", i, rvalid);
                return;
            end
            checks++;
            if (rdata !== exp) begin failures++; $display("FAIL rdata: beat %0d got %h, expected %h", i, rdata, exp); end
            checks++;
            if (rid !== id || rresp !== 2'd0) begin
                failures++; $display("FAIL rid_rresp: got %0d/%0d, expected %0d/0", rid, rresp, id);
            end
            checks++;
            if (rlast !== (i == len)) begin
                failures++; $display("FAIL rlast: beat %0d got %0b, expected %0b", i, rlast, (i == len));
            end
            rbuf[i] = rdata;
            @(negedge clk);
        end
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL r_end: rvalid=%0b after last beat, expected 0", rvalid); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1 || bvalid !== 1'b0 || rvalid !== 1'b0 || wready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: aw=%0b ar=%0b b=%0b r=%0b w=%0b, expected 1 1 0 0 0",
                     awready, arready, bvalid, rvalid, wready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (awready !== 1'b1 || arready !== 1'b1 || bvalid !== 1'b0 || rvalid !== 1'b0 || wready !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle: aw=%0b ar=%0b b=%0b r=%0b w=%0b, expected 1 1 0 0 0",
                         awready, arready, bvalid, rvalid, wready);
            end
        end
    endtask

    task automatic test_w_before_aw();
        @(negedge clk);
        wdata = 64'hDEAD; wstrb = 8'hFF; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wready !== 1'b0) begin failures++; $display("FAIL w_stall: wready=%0b, expected 0", wready); end
        end
        wvalid = 1'b0;
    endtask

    task automatic test_prefill();
        for (int i = 0; i < 256; i++) begin wbuf[i] = '0; sbuf[i] = 8'hFF; end
        do_write(6'd1, 32'h1000, 255, 3'd3, 2'd1);
        do_write(6'd2, 32'h1800, 255, 3'd3, 2'd1);
    endtask

    task automatic test_single();
        wbuf[0] = 64'h1122334455667788; sbuf[0] = 8'hFF;
        do_write(6'd5, 32'h100, 0, 3'd3, 2'd1);
        do_read(6'd3, 32'h100, 0, 3'd3, 2'd1, -1);
        checks++;
        if (rbuf[0] !== 64'h1122334455667788) begin
            failures++; $display("FAIL single: got %h, expected 1122334455667788", rbuf[0]);
        end
    endtask

    task automatic test_strobe();
        wbuf[0] = 64'hFFFFFFFFFFFFFFFF; sbuf[0] = 8'h0F;
        do_write(6'd7, 32'h100, 0, 3'd3, 2'd1);
        do_read(6'd8, 32'h100, 0, 3'd3, 2'd1, -1);
        checks++;
        if (rbuf[0] !== 64'h11223344FFFFFFFF) begin
            failures++; $display("FAIL strobe: got %h, expected 11223344ffffffff", rbuf[0]);
        end
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i); sbuf[i] = 8'hFF; end
        do_write(6'd9, 32'h200, 3, 3'd3, 2'd1);
        do_read(6'd10, 32'h200, 3, 3'd3, 2'd1, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rbuf[i] !== 64'(i)) begin failures++; $display("FAIL incr: beat %0d got %h, expected %0d", i, rbuf[i], i); end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] exp [0:3];
        exp[0] = 64'd2; exp[1] = 64'd3; exp[2] = 64'd0; exp[3] = 64'd1;
        do_read(6'd11, 32'h210, 3, 3'd3, 2'd2, -1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rbuf[i] !== exp[i]) begin failures++; $display("FAIL wrap: beat %0d got %h, expected %h", i, rbuf[i], exp[i]); end
        end
    endtask

    task automatic test_alias_concurrent();
        wbuf[0] = 64'hA5A5_0123_4567_89AB; sbuf[0] = 8'hFF;
        do_write(6'd12, MEM_SIZE + 32'h8, 0, 3'd3, 2'd1);
        do_read(6'd13, 32'h8, 0, 3'd3, 2'd1, -1);
        checks++;
        if (rbuf[0] !== 64'hA5A5_0123_4567_89AB) begin
            failures++; $display("FAIL alias: got %h, expected a5a5012345678 9ab", rbuf[0]);
        end
        wbuf[0] = 64'h0BAD_F00D_CAFE_BEEF; sbuf[0] = 8'hFF;
        fork
            do_write(6'd14, 32'h300, 0, 3'd3, 2'd1);
            do_read(6'd15, 32'h100, 0, 3'd3, 2'd1, -1);
        join
        checks++;
        if (aw_time !== ar_time) begin
            failures++; $display("FAIL concurrent_accept: aw at %0t, ar at %0t, expected same cycle", aw_time, ar_time);
        end
        do_read(6'd16, 32'h300, 0, 3'd3, 2'd1, -1);
    endtask

    task automatic test_random();
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [31:0] addr;
        int          len, step, hold;
        for (int t = 0; t < 24; t++) begin
            burst = 2'($urandom_range(0, 2));
            size  = 3'($urandom_range(0, 4));
            step  = 1 << ((size > 3) ? 3 : size);
            if (burst == 2'd2) begin
                case ($urandom_range(0, 3))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    default: len = 15;
                endcase
            end else begin
                len = $urandom_range(0, 15);
            end
            addr = 32'h1000 + $urandom_range(0, 32'hE00);
            if (burst == 2'd2) addr = addr - (addr % step);
            addr = addr + ($urandom_range(0, 3) << 16);
            for (int i = 0; i <= len; i++) begin
                wbuf[i] = {$urandom, $urandom};
                sbuf[i] = 8'($urandom_range(0, 255));
            end
            hold = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len) : -1;
            do_write(6'($urandom), addr, len, size, burst);
            do_read(6'($urandom), addr, len, size, burst, hold);
        end
    endtask

    initial begin
        test_reset();
        test_w_before_aw();
        test_prefill();
        test_single();
        test_strobe();
        test_incr();
        test_wrap();
        test_alias_concurrent();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
